// File: rtl/sdram_arbiter_rr.sv
// sdram_arbiter_rr: N-master arbiter (round-robin or fixed priority with aging) in front of a single-port SDRAM controller.
module sdram_arbiter_rr #(
    parameter int NUM_MASTERS = 4,
    parameter int ID_WIDTH    = 3,
    parameter int ADDR_WIDTH  = 26,
    parameter int DATA_WIDTH  = 32,
    parameter int ROUND_ROBIN = 1,
    parameter int MAX_WAIT    = 7
) (
    input  logic                                clock,
    input  logic                                reset,
    output logic [ID_WIDTH-1:0]                 sdram_req,
    output logic [ADDR_WIDTH-1:0]               sdram_addr,
    output logic                                sdram_write,
    output logic                                sdram_burst,
    output logic [DATA_WIDTH/8-1:0]             sdram_byte_enable,
    output logic [DATA_WIDTH-1:0]               sdram_wdata,
    input  logic                                sdram_ack,
    input  logic [DATA_WIDTH-1:0]               sdram_rdata,
    input  logic [ID_WIDTH-1:0]                 sdram_rdvalid,
    input  logic                                sdram_complete,
    input  logic [NUM_MASTERS-1:0]              bus_request,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   bus_addr,
    input  logic [NUM_MASTERS-1:0]              bus_write,
    input  logic [NUM_MASTERS-1:0]              bus_burst,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] bus_byte_enable,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   bus_wdata,
    output logic [NUM_MASTERS-1:0]              bus_ack,
    output logic [DATA_WIDTH-1:0]               bus_rdata,
    output logic [NUM_MASTERS-1:0]              bus_rdvalid,
    output logic [NUM_MASTERS-1:0]              bus_complete
);
    localparam int BW = DATA_WIDTH / 8;
    localparam int WW = MAX_WAIT > 0 ? $clog2(MAX_WAIT + 1) : 1;

    logic [ID_WIDTH-1:0] grant_q, rr_ptr_q, grant, win;
    logic [WW-1:0]       wait_cnt_q [NUM_MASTERS];
    logic                held, found;

    always_comb begin
        win   = '0;
        found = 1'b0;
        held  = 1'b0;
        if (ROUND_ROBIN != 0) begin
            for (int k = 1; k <= NUM_MASTERS; k++)
                if (!found && bus_request[(int'(rr_ptr_q) + k) % NUM_MASTERS]) begin
                    found = 1'b1;
                    win   = ID_WIDTH'((int'(rr_ptr_q) + k) % NUM_MASTERS + 1);
                end
        end else begin
            for (int i = NUM_MASTERS - 1; i >= 0; i--)
                if (bus_request[i]) win = ID_WIDTH'(i + 1);
            // an aged-out requester overrides plain priority
            if (MAX_WAIT > 0)
                for (int i = NUM_MASTERS - 1; i >= 0; i--)
                    if (bus_request[i] && wait_cnt_q[i] == WW'(MAX_WAIT)) win = ID_WIDTH'(i + 1);
        end
        for (int i = 0; i < NUM_MASTERS; i++)
            if (grant_q == ID_WIDTH'(i + 1) && bus_request[i]) held = 1'b1;
        grant = reset ? '0 : grant_q != '0 ? (held ? grant_q : '0) : win;
    end

    always_comb begin
        sdram_req         = grant;
        sdram_addr        = '0;
        sdram_write       = 1'b0;
        sdram_burst       = 1'b0;
        sdram_byte_enable = '0;
        sdram_wdata       = '0;
        bus_ack           = '0;
        for (int i = 0; i < NUM_MASTERS; i++)
            if (grant == ID_WIDTH'(i + 1)) begin
                sdram_addr        = bus_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sdram_write       = bus_write[i];
                sdram_burst       = bus_burst[i];
                sdram_byte_enable = bus_byte_enable[i*BW +: BW];
                sdram_wdata       = bus_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                bus_ack[i]        = sdram_ack;
            end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            grant_q  <= '0;
            rr_ptr_q <= ID_WIDTH'(NUM_MASTERS - 1);
            for (int i = 0; i < NUM_MASTERS; i++) wait_cnt_q[i] <= '0;
        end else begin
            if (sdram_ack && grant != '0) begin
                grant_q  <= '0;
                rr_ptr_q <= grant - ID_WIDTH'(1);
            end else begin
                grant_q <= grant;
            end
            for (int i = 0; i < NUM_MASTERS; i++)
                if (ROUND_ROBIN != 0 || !bus_request[i]) wait_cnt_q[i] <= '0;
                else if (sdram_ack && grant != '0) begin
                    if (grant == ID_WIDTH'(i + 1)) wait_cnt_q[i] <= '0;
                    else if (wait_cnt_q[i] != WW'(MAX_WAIT)) wait_cnt_q[i] <= wait_cnt_q[i] + WW'(1);
                end
        end
    end

    genvar g;
    for (g = 0; g < NUM_MASTERS; g++) begin : g_ret
        assign bus_rdvalid[g]  = sdram_rdvalid == ID_WIDTH'(g + 1);
        assign bus_complete[g] = bus_rdvalid[g] && sdram_complete;
    end
    assign bus_rdata = sdram_rdata;
endmodule

// File: doc/sdram_arbiter_rr.md
Name: sdram_arbiter_rr

Overview:
- Parametrised N-master arbiter in front of the single-port SDRAM controller; successor to the fixed 3-master priority arbiter.
- Grants one master at a time and holds the grant until the controller acks.
- Supports round-robin or fixed-priority-with-aging selection.
- Routes read data, rdvalid and complete back to the master tagged by the controller.

Parameters:
NUM_MASTERS, 4, number of bus masters (1..7)
ID_WIDTH, 3, width of master ID on controller side; must satisfy 2**ID_WIDTH > NUM_MASTERS
ADDR_WIDTH, 26, address width
DATA_WIDTH, 32, data width; multiple of 8
ROUND_ROBIN, 1, 1 = round-robin, 0 = fixed priority (lowest index wins) with aging
MAX_WAIT, 7, aging threshold in lost arbitrations (fixed mode only); 0 disables aging

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
sdram_req  out  ID_WIDTH  ID of granted master (master i -> i+1); 0 = idle
sdram_addr  out  ADDR_WIDTH  address of granted master
sdram_write  out  1  1 = write, 0 = read
sdram_burst  out  1  1 = burst, 0 = single
sdram_byte_enable  out  DATA_WIDTH/8  write byte enables
sdram_wdata  out  DATA_WIDTH  write data
sdram_ack  in  1  controller accepted current request
sdram_rdata  in  DATA_WIDTH  read data
sdram_rdvalid  in  ID_WIDTH  ID owning sdram_rdata; 0 = none
sdram_complete  in  1  last beat of current burst
bus_request  in  NUM_MASTERS  per-master request
bus_addr  in  NUM_MASTERS*ADDR_WIDTH  packed; master i at slice i
bus_write  in  NUM_MASTERS  per-master write flag
bus_burst  in  NUM_MASTERS  per-master burst flag
bus_byte_enable  in  NUM_MASTERS*DATA_WIDTH/8  packed byte enables
bus_wdata  in  NUM_MASTERS*DATA_WIDTH  packed write data
bus_ack  out  NUM_MASTERS  one-hot ack to granted master
bus_rdata  out  DATA_WIDTH  broadcast copy of sdram_rdata
bus_rdvalid  out  NUM_MASTERS  one-hot; bit i when sdram_rdvalid == i+1
bus_complete  out  NUM_MASTERS  bus_rdvalid[i] && sdram_complete

Behaviour:
- State registers:
  - grant_q (ID_WIDTH): reset 0.
  - rr_ptr_q (index of last acked master): reset NUM_MASTERS-1, so master 0 has first priority.
  - wait_cnt_q[i] (saturating, width clog2(MAX_WAIT+1)): reset 0.
- Effective grant (combinational):
  - If grant_q != 0 and that master's request is high: grant = grant_q (held).
  - If grant_q != 0 and that master's request is low (protocol violation; request withdrawn): grant = 0 this cycle, no re-arbitration until next cycle.
  - If grant_q == 0: grant = winner of the current requests (zero-cycle latency), or 0 if none.
- Winner selection:
  - ROUND_ROBIN=1: first requester scanning from (rr_ptr_q+1) mod NUM_MASTERS upward with wrap.
  - ROUND_ROBIN=0: lowest-index requester whose wait_cnt == MAX_WAIT (urgent, when MAX_WAIT>0); otherwise lowest-index requester.
- Output steering:
  - sdram_req = grant.
  - Address, write, burst, byte-enable and wdata are muxed from the granted master.
  - All steered outputs are 0 when grant == 0 (never X).
- Ack:
  - bus_ack[i] = sdram_ack && grant == i+1.
  - sdram_ack while grant == 0 is ignored.
- Next state:
  - reset: all registers to reset values.
  - else if sdram_ack && grant != 0: grant_q <= 0; rr_ptr_q <= grant-1. The next cycle re-arbitrates, so back-to-back grants are one request per cycle max.
  - else: grant_q <= grant.
- Aging (fixed mode):
  - On each ack to master j, every other requesting master i != j increments wait_cnt[i], saturating at MAX_WAIT.
  - wait_cnt[j] clears on its own ack.
  - wait_cnt[i] clears whenever bus_request[i] is low.
  - Counters held at 0 in round-robin mode.
- Return path:
  - Purely combinational; independent of grant (reads may return after grant moved on).
  - sdram_rdvalid of 0 or > NUM_MASTERS asserts no bus_rdvalid.
  - bus_rdata = sdram_rdata always.
- Reset mid-transfer: during the reset cycle sdram_req = 0 and bus_ack = 0 regardless of inputs; after reset, arbitration restarts from master 0.
- Masters must hold request and payload stable from assertion until bus_ack.

Test Plan:
- Single master: NUM_MASTERS=4, RR; master 2 requests addr 0x0001234, ack 3 cycles later -> sdram_req=3 same cycle as request, held 3 cycles, bus_ack=0b0100 one cycle, sdram_req=0 next cycle.
- Round-robin fairness: all 4 request continuously, ack every cycle -> grant IDs sequence 1,2,3,4,1,2 (idle cycle after each ack), each master acked once per 4 acks.
- Fixed priority with aging: ROUND_ROBIN=0, MAX_WAIT=3; masters 0 and 3 request continuously -> acks 0,0,0, then master 3 granted on 4th arbitration; its wait_cnt clears.
- Request withdrawal: master 1 granted, drops request before ack -> sdram_req=0 that cycle, grant_q=0 next cycle; master 0 then granted if requesting.
- Return routing: sdram_rdvalid=2 with rdata 0xDEADBEEF and complete=1 -> bus_rdvalid=0b0010, bus_complete=0b0010; sdram_rdvalid=6 -> all zero.
- Reset mid-grant: assert reset while master 3 holds grant -> sdram_req=0 in reset cycle; after release with all requesting, first grant ID=1 (RR).
